// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register with a valid/ready handshake, a one-entry skid buffer
// behind the output register, a flush that squashes the stage and a bubble counter.
module id_exe_pipe_reg #(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned ASIZE = 5,
  parameter int unsigned OPW   = 6,
  parameter int unsigned SRCW  = 2,
  parameter int unsigned IMMW  = 32,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] rdata1_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic [OPW-1:0]   op_in,
  input  logic [SRCW-1:0]  src_in,
  input  logic [IMMW-1:0]  signext_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             wen_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] a_out,
  output logic [DSIZE-1:0] b_out,
  output logic [OPW-1:0]   op_out,
  output logic [SRCW-1:0]  src_out,
  output logic [IMMW-1:0]  signext_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             wen_out,
  output logic [CNTW-1:0]  bubble_cnt
);

  localparam int unsigned PW = 2 * DSIZE + OPW + SRCW + IMMW + ASIZE + 1;

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   main_q, main_d;
  logic [PW-1:0]   skid_q, skid_d;
  logic            in_ready_q, in_ready_d;
  logic [CNTW-1:0] bubble_q, bubble_d;
  logic [PW-1:0]   in_pl;
  logic            main_wen;
  logic            acc, pop;

  assign in_pl = {rdata1_in, rdata2_in, op_in, src_in, signext_in, waddr_in, wen_in};
  assign {a_out, b_out, op_out, src_out, signext_out, waddr_out, main_wen} = main_q;

  assign out_valid  = (state_q != StEmpty);
  assign in_ready   = in_ready_q;
  assign wen_out    = main_wen & out_valid;
  assign bubble_cnt = bubble_q;

  assign acc = in_valid & in_ready_q;
  assign pop = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (acc) begin
          state_d = StBusy;
          main_d  = in_pl;
        end
      end
      StBusy: begin
        if (acc && pop) begin
          main_d = in_pl;
        end else if (acc) begin
          state_d = StFull;
          skid_d  = in_pl;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          state_d = StBusy;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Squash: payload registers keep their old contents so outputs hold while invalid.
    if (flush) begin
      state_d = StEmpty;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d = (state_d != StFull);
  end

  always_comb begin
    bubble_d = bubble_q;
    if (out_ready && !out_valid && (bubble_q != {CNTW{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      bubble_q   <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      bubble_q   <= bubble_d;
    end
  end

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Scoreboard bench for id_exe_pipe_reg: accepted instructions are queued as expected
// outputs and a negedge monitor checks every EXE-side handshake against the queue.
module tb_id_exe_pipe_reg;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  op;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [4:0]  waddr;
    logic        wen;
  } instr_t;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, wen_in, wen_out;
  logic [31:0] rdata1_in, rdata2_in, signext_in, a_out, b_out, signext_out;
  logic [5:0]  op_in, op_out;
  logic [1:0]  src_in, src_out;
  logic [4:0]  waddr_in, waddr_out;
  logic [1:0]  bubble_cnt;

  int     tests = 0;
  int     fails = 0;
  instr_t exp_q[$];

  id_exe_pipe_reg #(.CNTW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rdata1_in  (rdata1_in),
    .rdata2_in  (rdata2_in),
    .op_in      (op_in),
    .src_in     (src_in),
    .signext_in (signext_in),
    .waddr_in   (waddr_in),
    .wen_in     (wen_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_out      (a_out),
    .b_out      (b_out),
    .op_out     (op_out),
    .src_out    (src_out),
    .signext_out(signext_out),
    .waddr_out  (waddr_out),
    .wen_out    (wen_out),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t mk(input logic [5:0] op, input logic wen, input logic [4:0] waddr);
    instr_t x;
    x.a     = 32'hA000_0000 | {26'd0, op};
    x.b     = 32'hB000_0000 | {26'd0, op};
    x.op    = op;
    x.src   = op[1:0];
    x.imm   = 32'hFFFF_FF00 | {26'd0, op};
    x.waddr = waddr;
    x.wen   = wen;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input instr_t x);
    rdata1_in  = x.a;
    rdata2_in  = x.b;
    op_in      = x.op;
    src_in     = x.src;
    signext_in = x.imm;
    waddr_in   = x.waddr;
    wen_in     = x.wen;
  endtask

  // Holds the payload until accepted; the expectation is queued at acceptance.
  task automatic send(input instr_t x);
    bit done = 0;
    drive(x);
    in_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(x);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: op %0h never accepted", x.op);
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int n = 0; n < 50 && !done; n++) begin
      if (exp_q.size() == 0) done = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL drain: %0d instructions never emerged, expected 0 pending", exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      instr_t act, e;
      act = '{a_out, b_out, op_out, src_out, signext_out, waddr_out, wen_out};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL extra_output: got op %0h, expected no instruction", op_out);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL output: got %h expected %h", act, e);
        end
      end
    end
  end

  initial begin
    instr_t x;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive('0);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_bubble", bubble_cnt, 0);
    check("rst_a_out", a_out, 0);
    check("rst_wen_out", wen_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Streaming at full throughput
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(mk(6'(i), i[0], 5'(i)));
      check("stream_out_valid", out_valid, 1);
      check("stream_op_latency", op_out, 64'(i));
    end
    check("stream_bubble", bubble_cnt, 1);
    drain();

    // Backpressure fills the skid entry
    out_ready = 1'b0;
    send(mk(6'h0A, 1'b1, 5'd10));
    send(mk(6'h0B, 1'b0, 5'd11));
    fork
      send(mk(6'h0C, 1'b1, 5'd12));
      begin
        check("bp_in_ready_c3", in_ready, 0);
        @(posedge clk); #1;
        check("bp_in_ready_c4", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_head_a", op_out, 64'h0A);
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush while FULL with a new instruction offered
    out_ready = 1'b0;
    send(mk(6'h11, 1'b1, 5'd1));
    send(mk(6'h12, 1'b1, 5'd2));
    drive(mk(6'h1D, 1'b1, 5'd3));
    in_valid = 1'b1;
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_wen_out", wen_out, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("flush_stays_empty", out_valid, 0);

    // Bubble keeps stale payload but never writes
    out_ready = 1'b0;
    send(mk(6'h2A, 1'b1, 5'd5));
    check("stale_wen_valid", wen_out, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stale_out_valid", out_valid, 0);
    check("stale_wen_out", wen_out, 0);
    check("stale_waddr", waddr_out, 5);
    repeat (2) @(posedge clk);
    #1;
    check("stale_wen_out_later", wen_out, 0);
    check("stale_waddr_later", waddr_out, 5);

    // Saturating bubble counter (CNTW=2)
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("sat_rst_bubble", bubble_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check("sat_bubble", bubble_cnt, (k < 3) ? 64'(k) : 64'd3);
    end

    // Asynchronous reset mid-cycle while FULL
    out_ready = 1'b0;
    send(mk(6'h31, 1'b1, 5'd7));
    send(mk(6'h32, 1'b1, 5'd8));
    check("arst_pre_bubble", bubble_cnt, 3);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_wen_out", wen_out, 0);
    check("arst_a_out", a_out, 0);
    check("arst_bubble", bubble_cnt, 0);
    check("arst_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    x = mk(6'h33, 1'b1, 5'd9);
    send(x);
    check("arst_latency_valid", out_valid, 1);
    check("arst_latency_op", op_out, 64'h33);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
